spi_reg_peripheral: RTL and testbench

- SPI mode-0 peripheral that feeds the PWM stage inside tt_um_onboarding_echometer; exposes five 8-bit control registers: output enables, PWM enables, duty cycle.
- Samples the pin-level nCS/SCLK/COPI (from ui_in) in the system clock domain through synchronizers, then shifts in 16-bit write frames and commits them to the register file.
- The top level derives rst = ~rst_n and passes the register outputs straight to the PWM block.

---
 rtl/spi_reg_pkg.sv | 26 ++
 rtl/spi_reg_peripheral_sync_edge.sv | 38 +++
 rtl/spi_reg_peripheral.sv | 194 +++++++++++++++++++
 tb/tb_spi_reg_peripheral.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register peripheral.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 5;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  // Bit counter: 16 is a clean frame, saturates one past it so that any
  // overlong frame still reads as "not 16".
  localparam int         CNT_W    = 5;
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;
  localparam logic [4:0] CNT_HALF = 5'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus rise/fall detect
// against one extra registered copy of the synchronized value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  // Next values: shift the pin in at the bottom, remember the last stage.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_i};
    prev_d  = chain_q[STAGES-1];
  end

  // Synchronizer and history flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register peripheral (five 8-bit control registers).
// Optional macro SPI_READBACK_EN adds read frames driving cipo_o.
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ncs_i,
  input  logic       sclk_i,
  input  logic       copi_i,
  output logic       cipo_o,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_done_o,
  output logic       txn_err_o
);

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  logic ncs_s, ncs_rise, ncs_fall;
  logic sclk_rise;
  logic copi_s;
`ifdef SPI_READBACK_EN
  logic sclk_fall;
`endif

  sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ncs_i),
    .sync_o (ncs_s),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sclk_i),
    .sync_o (),
    .rise_o (sclk_rise),
`ifdef SPI_READBACK_EN
    .fall_o (sclk_fall)
`else
    .fall_o ()
`endif
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_copi (
    .clk    (clk),
    .rst    (rst),
    .d_i    (copi_i),
    .sync_o (copi_s),
    .rise_o (),
    .fall_o ()
  );

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]    shreg_q, shreg_d;
  logic [NUM_REGS-1:0][7:0] regs_q, regs_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic [6:0] addr;
  logic       addr_ok;

  assign addr    = shreg_q[14:8];
  assign addr_ok = (addr <= MAX_A) && (addr < 7'(NUM_REGS));

  // Frame FSM: shift on synced SCLK rises, judge and commit after nCS rises.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    regs_d  = regs_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // nCS release wins over a coincident SCLK rise: that bit is dropped.
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise && !ncs_s) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q == CNT_FULL) begin
          done_d = 1'b1;
          if (shreg_q[15] && addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr == 7'(i)) regs_d[i] = shreg_q[7:0];
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, datapath and register-file flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      regs_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      regs_q  <= regs_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO[2:0]];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI[2:0]];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO[2:0]];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI[2:0]];
  assign pwm_duty_cycle  = regs_q[ADDR_DUTY[2:0]];
  assign txn_done_o      = done_q;
  assign txn_err_o       = err_q;

`ifdef SPI_READBACK_EN
  logic [7:0] tx_q, tx_d;
  logic       cipo_q, cipo_d;
  logic [7:0] rd_data;

  // Register selected by the address byte already shifted in (shreg[6:0]).
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shreg_q[6:0] == 7'(i) && shreg_q[6:0] <= MAX_A) rd_data = regs_q[i];
    end
  end

  // Tx shifter: load on the fall after the 8th rise of a read, then shift
  // one bit per synced SCLK fall; idle low while nCS is high.
  always_comb begin
    tx_d   = tx_q;
    cipo_d = cipo_q;
    if (ncs_s) begin
      tx_d   = 8'h00;
      cipo_d = 1'b0;
    end else if (state_q == SHIFT && sclk_fall) begin
      if (cnt_q == CNT_HALF && !shreg_q[7]) begin
        cipo_d = rd_data[7];
        tx_d   = {rd_data[6:0], 1'b0};
      end else if (cnt_q > CNT_HALF) begin
        cipo_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  // Tx flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q   <= 8'h00;
      cipo_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      cipo_q <= cipo_d;
    end
  end

  assign cipo_o = cipo_q;
`else
  assign cipo_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: vector table of SPI frames plus
// hand sequences for latency, idle SCLK, mid-frame reset and readback.
module tb_spi_reg_peripheral;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst, ncs, sclk, copi;
  logic       cipo;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       done, err;

  spi_reg_peripheral #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .ncs_i           (ncs),
    .sclk_i          (sclk),
    .copi_i          (copi),
    .cipo_o          (cipo),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .txn_done_o      (done),
    .txn_err_o       (err)
  );

  always #5 clk = ~clk;

  logic [39:0] regs_now;
  assign regs_now = {r4, r3, r2, r1, r0};

  int done_cnt = 0;
  int err_cnt  = 0;
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    ncs = 1'b0;
    tick(6);
  endtask

  // Clock out n bits MSB first; cipo is sampled just before each rise.
  task automatic send_bits(input logic [31:0] bits, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      tick(5);
      rx   = {rx[30:0], cipo};
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_end();
    tick(5);
    ncs = 1'b1;
    tick(12);
  endtask

  typedef struct {
    logic [31:0] bits;
    int          n;
    logic [39:0] regs;   // {duty, pwm_hi, pwm_lo, out_hi, out_lo}
    int          ndone;
    int          nerr;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] rx;
  int d0, e0;

  initial begin
    vecs[0] = '{32'h80F0,  16, 40'h00_00_00_00_F0, 1, 0};
    vecs[1] = '{32'h8480,  16, 40'h80_00_00_00_F0, 1, 0};
    vecs[2] = '{32'h85AA,  16, 40'h80_00_00_00_F0, 1, 0};
    vecs[3] = '{32'h0000,  16, 40'h80_00_00_00_F0, 1, 0};
    vecs[4] = '{32'h080F,  12, 40'h80_00_00_00_F0, 0, 1};
    vecs[5] = '{32'hFFFFF, 20, 40'h80_00_00_00_F0, 0, 1};
    vecs[6] = '{32'h82FF,  16, 40'h80_00_FF_00_F0, 1, 0};
    vecs[7] = '{32'h8155,  16, 40'h80_00_FF_55_F0, 1, 0};
    vecs[8] = '{32'h8400,  16, 40'h00_00_FF_55_F0, 1, 0};

    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(20);
    chk("reset_regs", regs_now, 40'h0);
    chk("reset_cipo", {39'h0, cipo}, 40'h0);
    chk("reset_done", 40'(done_cnt), 40'h0);
    chk("reset_err",  40'(err_cnt),  40'h0);

    for (int v = 0; v < 9; v++) begin
      d0 = done_cnt; e0 = err_cnt;
      frame_begin();
      send_bits(vecs[v].bits, vecs[v].n, rx);
      frame_end();
      chk($sformatf("vec%0d_regs", v), regs_now, vecs[v].regs);
      chk($sformatf("vec%0d_done", v), 40'(done_cnt - d0), 40'(vecs[v].ndone));
      chk($sformatf("vec%0d_err", v),  40'(err_cnt - e0),  40'(vecs[v].nerr));
    end

    // Latency: update lands on the SYNC_STAGES+2'th edge after nCS rise.
    frame_begin();
    send_bits(32'h8311, 16, rx);
    tick(5);
    ncs = 1'b1;
    tick(SYNC_STAGES + 1);
    chk("lat_before", {32'h0, r3}, 40'h00);
    tick(1);
    chk("lat_after", {32'h0, r3}, 40'h11);
    tick(10);

    // SCLK toggling with nCS high is ignored.
    d0 = done_cnt; e0 = err_cnt;
    copi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(5); sclk = 1'b1; tick(5); sclk = 1'b0;
    end
    tick(10);
    chk("idle_sclk_regs", regs_now, 40'h00_11_FF_55_F0);
    chk("idle_sclk_done", 40'(done_cnt - d0), 40'h0);
    chk("idle_sclk_err",  40'(err_cnt - e0),  40'h0);

    // Reset after 9 bits of 0x8133: frame discarded, not resumed.
    d0 = done_cnt; e0 = err_cnt;
    frame_begin();
    send_bits(32'h8133 >> 7, 9, rx);
    tick(2);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    ncs = 1'b1;
    tick(12);
    chk("midrst_regs", regs_now, 40'h0);
    chk("midrst_done", 40'(done_cnt - d0), 40'h0);
    chk("midrst_err",  40'(err_cnt - e0),  40'h0);
    frame_begin();
    send_bits(32'h8133, 16, rx);
    frame_end();
    chk("postrst_regs", regs_now, 40'h00_00_00_33_00);
    chk("postrst_done", 40'(done_cnt - d0), 40'h1);

`ifdef SPI_READBACK_EN
    frame_begin();
    send_bits(32'h835A, 16, rx);
    frame_end();
    d0 = done_cnt;
    frame_begin();
    send_bits(32'h0300, 16, rx);
    frame_end();
    chk("rb_data", {32'h0, rx[7:0]}, 40'h5A);
    chk("rb_reg",  {32'h0, r3}, 40'h5A);
    chk("rb_done", 40'(done_cnt - d0), 40'h1);
    chk("rb_cipo_idle", {39'h0, cipo}, 40'h0);
`else
    frame_begin();
    send_bits(32'h0300, 16, rx);
    frame_end();
    chk("no_rb_cipo", {8'h0, rx}, 40'h0);
    chk("no_rb_regs", regs_now, 40'h00_00_00_33_00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
